// File: rtl/rggen_rtl_pkg.sv
// Shared register-bus types: access direction, response status and slave hit classification.
package rggen_rtl_pkg;

  typedef enum logic {
    RGGEN_READ  = 1'b0,
    RGGEN_WRITE = 1'b1
  } rggen_direction;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

  localparam int unsigned RGGEN_STATUS_WIDTH = $bits(rggen_status);

  typedef enum logic [1:0] {
    RGGEN_HIT_NONE  = 2'b00,
    RGGEN_HIT_ONE   = 2'b01,
    RGGEN_HIT_MULTI = 2'b10
  } rggen_hit_class;

endpackage

// File: rtl/rggen_register_response_mux.sv
// Select-qualified OR merge of slave responses plus a none/one/multi classification of the select vector.
module rggen_register_response_mux
  import rggen_rtl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REGISTERS  = 4
)(
  input  logic [REGISTERS-1:0]                    i_select,
  input  logic [REGISTERS-1:0]                    i_ready,
  input  logic [REGISTERS*DATA_WIDTH-1:0]         i_read_data,
  input  logic [REGISTERS*RGGEN_STATUS_WIDTH-1:0] i_status,
  output rggen_hit_class                          o_hit_class_c,
  output logic                                    o_ready_c,
  output logic [DATA_WIDTH-1:0]                   o_read_data_c,
  output rggen_status                             o_status_c
);

  localparam int unsigned COUNT_WIDTH = $clog2(REGISTERS + 1);

  logic [COUNT_WIDTH-1:0]        hit_count;
  logic                          ready_or;
  logic [DATA_WIDTH-1:0]         data_or;
  logic [RGGEN_STATUS_WIDTH-1:0] status_or;

  always_comb begin
    hit_count = '0;
    ready_or  = 1'b0;
    data_or   = '0;
    status_or = '0;
    for (int unsigned k = 0; k < REGISTERS; k++) begin
      hit_count = hit_count + COUNT_WIDTH'(i_select[k]);
      if (i_select[k]) begin
        ready_or  = ready_or | i_ready[k];
        data_or   = data_or | i_read_data[k*DATA_WIDTH +: DATA_WIDTH];
        status_or = status_or | i_status[k*RGGEN_STATUS_WIDTH +: RGGEN_STATUS_WIDTH];
      end
    end
  end

  always_comb begin
    o_hit_class_c = RGGEN_HIT_MULTI;
    if (hit_count == '0) begin
      o_hit_class_c = RGGEN_HIT_NONE;
    end else if (hit_count == COUNT_WIDTH'(1)) begin
      o_hit_class_c = RGGEN_HIT_ONE;
    end
  end

  assign o_ready_c     = ready_or;
  assign o_read_data_c = data_or;
  assign o_status_c    = rggen_status'(status_or);

endmodule

// File: rtl/rggen_register_access_controller.sv
// Host-side register bus sequencer: latches one host access, broadcasts it to all slaves,
// resolves decode/multi-hit/timeout conditions and returns a single registered response.
module rggen_register_access_controller
  import rggen_rtl_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REGISTERS      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
)(
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    i_host_request,
  input  logic [ADDRESS_WIDTH-1:0]                i_host_address,
  input  rggen_direction                          i_host_direction,
  input  logic [DATA_WIDTH-1:0]                   i_host_write_data,
  input  logic [DATA_WIDTH/8-1:0]                 i_host_strobe,
  output logic                                    o_host_ready,
  output logic [DATA_WIDTH-1:0]                   o_host_read_data,
  output rggen_status                             o_host_status,
  output logic                                    o_request,
  output logic [ADDRESS_WIDTH-1:0]                o_address,
  output rggen_direction                          o_direction,
  output logic [DATA_WIDTH-1:0]                   o_write_data,
  output logic [DATA_WIDTH/8-1:0]                 o_write_strobe,
  output logic [DATA_WIDTH-1:0]                   o_write_mask,
  input  logic [REGISTERS-1:0]                    i_select,
  input  logic [REGISTERS-1:0]                    i_ready,
  input  logic [REGISTERS*DATA_WIDTH-1:0]         i_read_data,
  input  logic [REGISTERS*RGGEN_STATUS_WIDTH-1:0] i_status
);

  localparam int unsigned STROBE_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned TIMER_WIDTH  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ACCESS  = 2'b01,
    RESPOND = 2'b10
  } state_e;

  state_e                    state, state_next;
  logic [TIMER_WIDTH-1:0]    timer, timer_next;
  logic                      request_next;
  logic                      host_ready_next;
  logic [DATA_WIDTH-1:0]     host_read_data_next;
  rggen_status               host_status_next;
  logic [ADDRESS_WIDTH-1:0]  address_next;
  rggen_direction            direction_next;
  logic [DATA_WIDTH-1:0]     write_data_next;
  logic [STROBE_WIDTH-1:0]   write_strobe_next;
  logic [DATA_WIDTH-1:0]     write_mask_next;

  rggen_hit_class            hit_class;
  logic                      merged_ready;
  logic [DATA_WIDTH-1:0]     merged_read_data;
  rggen_status               merged_status;

  rggen_register_response_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .REGISTERS  (REGISTERS)
  ) u_response_mux (
    .i_select      (i_select),
    .i_ready       (i_ready),
    .i_read_data   (i_read_data),
    .i_status      (i_status),
    .o_hit_class_c (hit_class),
    .o_ready_c     (merged_ready),
    .o_read_data_c (merged_read_data),
    .o_status_c    (merged_status)
  );

  // State, timer and every bus-facing output are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      timer            <= '0;
      o_request        <= 1'b0;
      o_host_ready     <= 1'b0;
      o_host_read_data <= '0;
      o_host_status    <= RGGEN_OKAY;
      o_address        <= '0;
      o_direction      <= RGGEN_READ;
      o_write_data     <= '0;
      o_write_strobe   <= '0;
      o_write_mask     <= '0;
    end else begin
      state            <= state_next;
      timer            <= timer_next;
      o_request        <= request_next;
      o_host_ready     <= host_ready_next;
      o_host_read_data <= host_read_data_next;
      o_host_status    <= host_status_next;
      o_address        <= address_next;
      o_direction      <= direction_next;
      o_write_data     <= write_data_next;
      o_write_strobe   <= write_strobe_next;
      o_write_mask     <= write_mask_next;
    end
  end

  always_comb begin
    state_next          = state;
    timer_next          = timer;
    request_next        = o_request;
    host_ready_next     = 1'b0;
    host_read_data_next = o_host_read_data;
    host_status_next    = o_host_status;
    address_next        = o_address;
    direction_next      = o_direction;
    write_data_next     = o_write_data;
    write_strobe_next   = o_write_strobe;
    write_mask_next     = o_write_mask;

    case (state)
      IDLE: begin
        if (i_host_request) begin
          address_next      = i_host_address;
          direction_next    = i_host_direction;
          write_data_next   = i_host_write_data;
          write_strobe_next = i_host_strobe;
          for (int unsigned i = 0; i < STROBE_WIDTH; i++) begin
            write_mask_next[i*8 +: 8] = {8{i_host_strobe[i]}};
          end
          timer_next   = '0;
          request_next = 1'b1;
          state_next   = ACCESS;
        end
      end
      // Priority: bad decode, then selected ready, then timeout, else keep waiting.
      ACCESS: begin
        if (hit_class != RGGEN_HIT_ONE) begin
          host_read_data_next = '0;
          host_status_next    = RGGEN_DECODE_ERROR;
          host_ready_next     = 1'b1;
          request_next        = 1'b0;
          state_next          = RESPOND;
        end else if (merged_ready) begin
          host_read_data_next = (o_direction == RGGEN_WRITE) ? '0 : merged_read_data;
          host_status_next    = merged_status;
          host_ready_next     = 1'b1;
          request_next        = 1'b0;
          state_next          = RESPOND;
        end else if (timer == TIMER_LAST) begin
          host_read_data_next = '0;
          host_status_next    = RGGEN_SLAVE_ERROR;
          host_ready_next     = 1'b1;
          request_next        = 1'b0;
          state_next          = RESPOND;
        end else begin
          timer_next = timer + TIMER_WIDTH'(1);
        end
      end
      RESPOND: begin
        timer_next = '0;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rggen_register_access_controller.sv
// Randomized bench for the register access controller, checked against a behavioural response model.
module tb_rggen_register_access_controller;
  import rggen_rtl_pkg::*;

  localparam int unsigned AW   = 16;
  localparam int unsigned DW   = 32;
  localparam int unsigned REGS = 4;
  localparam int unsigned TO   = 4;
  localparam int unsigned SW   = DW / 8;
  localparam int unsigned STW  = $bits(rggen_status);
  localparam int unsigned STB  = REGS * STW;
  localparam int NEVER = 1000;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 i_host_request;
  logic [AW-1:0]        i_host_address;
  rggen_direction       i_host_direction;
  logic [DW-1:0]        i_host_write_data;
  logic [SW-1:0]        i_host_strobe;
  logic                 o_host_ready;
  logic [DW-1:0]        o_host_read_data;
  rggen_status          o_host_status;
  logic                 o_request;
  logic [AW-1:0]        o_address;
  rggen_direction       o_direction;
  logic [DW-1:0]        o_write_data;
  logic [SW-1:0]        o_write_strobe;
  logic [DW-1:0]        o_write_mask;
  logic [REGS-1:0]      i_select;
  logic [REGS-1:0]      i_ready;
  logic [REGS*DW-1:0]   i_read_data;
  logic [STB-1:0]       i_status;

  int tests = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rggen_register_access_controller #(
    .ADDRESS_WIDTH  (AW),
    .DATA_WIDTH     (DW),
    .REGISTERS      (REGS),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_host_request    (i_host_request),
    .i_host_address    (i_host_address),
    .i_host_direction  (i_host_direction),
    .i_host_write_data (i_host_write_data),
    .i_host_strobe     (i_host_strobe),
    .o_host_ready      (o_host_ready),
    .o_host_read_data  (o_host_read_data),
    .o_host_status     (o_host_status),
    .o_request         (o_request),
    .o_address         (o_address),
    .o_direction       (o_direction),
    .o_write_data      (o_write_data),
    .o_write_strobe    (o_write_strobe),
    .o_write_mask      (o_write_mask),
    .i_select          (i_select),
    .i_ready           (i_ready),
    .i_read_data       (i_read_data),
    .i_status          (i_status)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One host access; slave behaviour: selected slave asserts ready after 'delay' wait cycles.
  task automatic do_access(input string tag, input logic [AW-1:0] addr, input rggen_direction dir,
                           input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                           input logic [REGS-1:0] sel, input int delay,
                           input logic [DW-1:0] rd, input rggen_status st);
    int            idx;
    int            exp_cycles;
    logic [DW-1:0] exp_data;
    rggen_status   exp_status;
    logic [DW-1:0] exp_mask;
    logic [REGS*DW-1:0] rdata_bus;
    logic [STB-1:0]     st_bus;
    int            n;
    int            req_cycles;
    int            ready_at;
    logic [DW-1:0] got_data;
    rggen_status   got_status;

    idx = 0;
    for (int k = 0; k < int'(REGS); k++) if (sel[k]) idx = k;
    rdata_bus = {$urandom(), $urandom(), $urandom(), $urandom()};
    st_bus    = STB'($urandom());
    rdata_bus[idx*DW +: DW]   = rd;
    st_bus[idx*STW +: STW]    = st;

    if ($countones(sel) != 1) begin
      exp_cycles = 1;
      exp_status = RGGEN_DECODE_ERROR;
      exp_data   = '0;
    end else if (delay < int'(TO)) begin
      exp_cycles = delay + 1;
      exp_status = st;
      exp_data   = (dir == RGGEN_WRITE) ? '0 : rd;
    end else begin
      exp_cycles = int'(TO);
      exp_status = RGGEN_SLAVE_ERROR;
      exp_data   = '0;
    end
    exp_mask = '0;
    for (int k = 0; k < int'(SW); k++) if (strb[k]) exp_mask = exp_mask | (DW'(32'hFF) << (8 * k));

    @(negedge clk);
    i_host_request    = 1'b1;
    i_host_address    = addr;
    i_host_direction  = dir;
    i_host_write_data = wdata;
    i_host_strobe     = strb;
    i_select          = sel;
    i_read_data       = rdata_bus;
    i_status          = st_bus;
    i_ready           = REGS'($urandom()) & ~sel;

    n = 0; req_cycles = 0; ready_at = 0;
    got_data = '0; got_status = RGGEN_OKAY;
    while (ready_at == 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (o_request) begin
        req_cycles++;
        check_eq({tag, "_addr"}, 64'(o_address), 64'(addr));
        check_eq({tag, "_wdata"}, 64'(o_write_data), 64'(wdata));
        if (req_cycles == 1) begin
          check_eq({tag, "_dir"}, 64'(o_direction), 64'(dir));
          check_eq({tag, "_strobe"}, 64'(o_write_strobe), 64'(strb));
          check_eq({tag, "_mask"}, 64'(o_write_mask), 64'(exp_mask));
        end
      end
      if (o_host_ready) begin
        ready_at       = n;
        got_data       = o_host_read_data;
        got_status     = o_host_status;
        i_host_request = 1'b0;
      end
      i_ready = REGS'($urandom()) & ~sel;
      if (o_request && (req_cycles - 1) == delay) i_ready = i_ready | sel;
    end
    i_host_request = 1'b0;
    check_eq({tag, "_latency"}, 64'(ready_at), 64'(exp_cycles + 1));
    check_eq({tag, "_req_cycles"}, 64'(req_cycles), 64'(exp_cycles));
    check_eq({tag, "_rdata"}, 64'(got_data), 64'(exp_data));
    check_eq({tag, "_status"}, 64'(got_status), 64'(exp_status));
    @(posedge clk); #1;
    i_ready = '0;
    check_eq({tag, "_ready_pulse"}, 64'(o_host_ready), 64'(0));
    check_eq({tag, "_req_after"}, 64'(o_request), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [REGS-1:0] sel;
    int r;
    rst_n = 1'b0;
    i_host_request = 1'b0; i_host_address = '0; i_host_direction = RGGEN_READ;
    i_host_write_data = '0; i_host_strobe = '0;
    i_select = '0; i_ready = '0; i_read_data = '0; i_status = '0;
    #12;
    check_eq("rst_request", 64'(o_request), 64'(0));
    check_eq("rst_host_ready", 64'(o_host_ready), 64'(0));
    check_eq("rst_rdata", 64'(o_host_read_data), 64'(0));
    check_eq("rst_status", 64'(o_host_status), 64'(RGGEN_OKAY));
    check_eq("rst_addr", 64'(o_address), 64'(0));
    check_eq("rst_dir", 64'(o_direction), 64'(RGGEN_READ));
    check_eq("rst_wdata", 64'(o_write_data), 64'(0));
    check_eq("rst_strobe", 64'(o_write_strobe), 64'(0));
    @(negedge clk); rst_n = 1'b1;

    do_access("rd_reg1", 16'h0004, RGGEN_READ, 32'h0, 4'hF, 4'b0010, 0, 32'hDEADBEEF, RGGEN_OKAY);
    do_access("wr_reg0", 16'h0000, RGGEN_WRITE, 32'h12345678, 4'b0101, 4'b0001, 0, 32'hCAFEF00D, RGGEN_OKAY);
    do_access("dec_none", 16'h0100, RGGEN_READ, 32'h0, 4'hF, 4'b0000, 0, 32'h11111111, RGGEN_OKAY);
    do_access("dec_multi", 16'h0008, RGGEN_READ, 32'h0, 4'hF, 4'b0011, 0, 32'h22222222, RGGEN_OKAY);
    do_access("timeout", 16'h000C, RGGEN_READ, 32'h0, 4'hF, 4'b1000, NEVER, 32'h33333333, RGGEN_OKAY);
    do_access("after_to", 16'h000C, RGGEN_READ, 32'h0, 4'hF, 4'b1000, 2, 32'h44444444, RGGEN_EXOKAY);
    do_access("slv_err", 16'h0008, RGGEN_READ, 32'h0, 4'hF, 4'b0100, 3, 32'h55555555, RGGEN_SLAVE_ERROR);

    // Reset while an access is outstanding must drop it silently.
    @(negedge clk);
    i_host_request = 1'b1; i_host_address = 16'h0004; i_host_direction = RGGEN_READ;
    i_select = 4'b0010; i_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("mid_req_high", 64'(o_request), 64'(1));
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_req", 64'(o_request), 64'(0));
    check_eq("mid_rst_ready", 64'(o_host_ready), 64'(0));
    i_host_request = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      check_eq("mid_rst_hold", 64'(o_host_ready), 64'(0));
    end
    @(negedge clk); rst_n = 1'b1;
    do_access("post_rst", 16'h0004, RGGEN_READ, 32'h0, 4'hF, 4'b0010, 1, 32'hA5A5F00F, RGGEN_OKAY);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7) begin
        sel = REGS'(1) << $urandom_range(0, REGS - 1);
      end else if (r == 7) begin
        sel = '0;
      end else begin
        sel = REGS'($urandom());
        while ($countones(sel) < 2) sel = REGS'($urandom());
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_access($sformatf("rand%0d", i), AW'($urandom()), rggen_direction'($urandom_range(0, 1)),
                $urandom(), SW'($urandom()), sel, $urandom_range(0, 5), $urandom(),
                rggen_status'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
